pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Registered program-counter unit for the single-cycle core; successor to the combinational next-PC selector.
//  Holds the PC and evaluates the 8 branch conditions against N/Z/V flags.
//  Adds register-indirect branches, call/return through a parametrised return-address stack (RAS), stall and sticky halt.
//  Sits between the instruction-memory address port and the decode/flag logic.
// PARAMETERS
//  ADDR_W     16  PC/address width; all PC arithmetic is modulo 2^ADDR_W
//  IMM_W       9  branch immediate width; sign-extended to ADDR_W, then shifted left by 1
//  RAS_DEPTH   4  return-address stack entries (>=2, power of 2)
//  RESET_PC    0  PC value loaded on reset
// PORTS
//  clk         in   1       clock, rising edge
//  rst_n       in   1       asynchronous reset, active-low
//  stall       in   1       hold all state this cycle
//  halt        in   1       current instruction is HLT
//  br_en       in   1       current instruction is a conditional branch
//  br_reg      in   1       1: target = reg_target; 0: target = pc_plus2 + (sext(imm)<<1)
//  cond        in   3       condition code
//  flags       in   3       [0]=N [1]=Z [2]=V
//  imm         in   IMM_W   branch offset in halfwords
//  reg_target  in   ADDR_W  register-indirect target
//  call        in   1       unconditional jump to branch target; pushes pc_plus2
//  ret         in   1       jump to popped RAS entry
//  pc          out  ADDR_W  current PC (registered)
//  pc_plus2    out  ADDR_W  pc+2 (combinational from pc)
//  taken       out  1       current instruction redirects the PC (combinational)
//  halted      out  1       sticky halt status (registered)
//  ras_empty   out  1       RAS holds 0 entries
//  ras_full    out  1       RAS holds RAS_DEPTH entries
//  ras_err     out  1       one-cycle registered pulse on RAS misuse
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - pc=RESET_PC, halted=0, ras_err=0.
//   - RAS count=0, so ras_empty=1 and ras_full=0.
//   - taken forced 0.
//  Condition codes (cond_true):
//   000 !Z    001 Z     010 !Z&!N    011 N
//   100 Z|!N  101 N|Z   110 V        111 always
//  Next-PC priority, evaluated only when !stall && !halted:
//   1. halt: pc holds; halted<=1, sticky until reset; taken=0.
//   2. call&ret both 1: pc<=pc_plus2; RAS unchanged; ras_err<=1.
//   3. ret: pc<=top of RAS and pop; taken=1.
//      If the RAS is empty: pc<=pc_plus2, taken=0, ras_err<=1.
//   4. call: pc<=target, push pc_plus2, taken=1.
//      If the RAS is full: overwrite the oldest entry (circular); count stays RAS_DEPTH; no error.
//   5. br_en && cond_true: pc<=target, taken=1.
//   6. otherwise: pc<=pc_plus2, taken=0.
//  Stall: pc, halted, RAS and ras_err all hold (ras_err drops to 0). taken is still reported.
//  Halted: all inputs ignored and taken=0; only reset exits.
//  Arithmetic: targets and pc_plus2 wrap modulo 2^ADDR_W with no overflow flag.
//   - Example: 0xFFFE+2 = 0x0000.
//  Latency: a redirect is visible on pc one cycle after the instruction is presented.
//  ras_err is high for exactly one cycle per offending instruction.
//  Reset asserted mid-operation clears the RAS contents pointer immediately; stale entry data is don't-care.
// STRUCTURE
//  Package pc_pkg:
//   - cond-code localparams (COND_NEQ..COND_UNC)
//   - flag indices FLAG_N/FLAG_Z/FLAG_V
//   - cond_eval function
//  Sub-module ras_stack (DEPTH, W):
//   - push, pop, push_data -> top, empty, full
//   - circular top pointer with a saturating count
//  Top level: PC register, halt flag, target mux, priority logic.
// TESTING
//  T1 reset: rst_n=0 mid-run -> pc=0, halted=0, ras_empty=1, taken=0 asynchronously.
//  T2 cond sweep, pc=0x0010, imm=9'h1FF (-1):
//   - each cond x all 8 flag combos; taken matches the table.
//   - target = 0x0012-2 = 0x0010.
//  T3 wrap: pc=0xFFFE sequential -> 0x0000.
//   - pc=0x0000, imm=9'h100, cond=111 -> 0x0002-0x0200 = 0xFE02.
//  T4 RAS (depth 4): 5 calls from pc 0x0100,0x0200,... then 5 rets:
//   - the first 4 rets return to the newest 4 links in LIFO order.
//   - the 5th ret finds the stack empty -> ras_err pulse, pc=pc_plus2.
//  T5 call&ret together -> ras_err=1 for 1 cycle, pc+=2, ras count unchanged.
//  T6 stall/halt:
//   - stall 3 cycles during a taken branch -> pc frozen, then redirects once.
//   - halt -> pc frozen, halted=1, later branches ignored until rst_n.

Source files
------------

// File: rtl/pc_pkg.sv
// pc_pkg: condition codes, flag indices and branch condition evaluation
package pc_pkg;
  localparam logic [2:0] COND_NEQ  = 3'b000;
  localparam logic [2:0] COND_EQ   = 3'b001;
  localparam logic [2:0] COND_GT   = 3'b010;
  localparam logic [2:0] COND_LT   = 3'b011;
  localparam logic [2:0] COND_GTE  = 3'b100;
  localparam logic [2:0] COND_LTE  = 3'b101;
  localparam logic [2:0] COND_OVFL = 3'b110;
  localparam logic [2:0] COND_UNC  = 3'b111;
  localparam int FLAG_N = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 2;
  function automatic logic cond_eval(input logic [2:0] cond, input logic [2:0] flags);
    logic n, z, v;
    logic [7:0] t;
    n = flags[FLAG_N];
    z = flags[FLAG_Z];
    v = flags[FLAG_V];
    t = {1'b1, v, n | z, z | ~n, n, ~z & ~n, z, ~z};
    return t[cond];
  endfunction
endpackage

// File: rtl/ras_stack.sv
// ras_stack: circular return-address stack with saturating occupancy count
module ras_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         full
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] ptr;
  logic [PW:0] cnt;
  always_ff @(posedge clk)
    if (push) mem[ptr] <= push_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ptr <= '0;
      cnt <= '0;
    end else if (push) begin
      ptr <= ptr + PW'(1);
      cnt <= full ? cnt : cnt + (PW+1)'(1);
    end else if (pop) begin
      ptr <= ptr - PW'(1);
      cnt <= cnt - (PW+1)'(1);
    end
  assign top   = mem[ptr - PW'(1)];
  assign empty = cnt == '0;
  assign full  = cnt == (PW+1)'(DEPTH);
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: registered PC with conditional/indirect branches, call/return stack, stall and sticky halt
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int IMM_W     = 9,
  parameter int RAS_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              halt,
  input  logic              br_en,
  input  logic              br_reg,
  input  logic [2:0]        cond,
  input  logic [2:0]        flags,
  input  logic [IMM_W-1:0]  imm,
  input  logic [ADDR_W-1:0] reg_target,
  input  logic              call,
  input  logic              ret,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus2,
  output logic              taken,
  output logic              halted,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_err
);
  logic [ADDR_W-1:0] target, pc_next, ras_top, offset;
  logic both, advance, push, pop, err_next;
  assign offset   = {{(ADDR_W-IMM_W){imm[IMM_W-1]}}, imm} << 1;
  assign pc_plus2 = pc + ADDR_W'(2);
  assign target   = br_reg ? reg_target : pc_plus2 + offset;
  assign both     = call & ret;
  assign taken    = rst_n & ~halted & ~halt & ~both & (ret ? ~ras_empty : (call | (br_en & cond_eval(cond, flags))));
  assign pc_next  = ~taken ? pc_plus2 : ret ? ras_top : target;
  assign advance  = ~stall & ~halted & ~halt;
  assign push     = advance & call & ~ret;
  assign pop      = advance & ret & ~call & ~ras_empty;
  assign err_next = advance & (both | (ret & ras_empty));
  ras_stack #(.DEPTH(RAS_DEPTH), .W(ADDR_W)) u_ras (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .pop(pop),
    .push_data(pc_plus2),
    .top(ras_top),
    .empty(ras_empty),
    .full(ras_full)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc      <= RESET_PC;
      halted  <= 1'b0;
      ras_err <= 1'b0;
    end else begin
      ras_err <= err_next;
      if (!stall && !halted) begin
        halted <= halt;
        if (!halt) pc <= pc_next;
      end
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scoreboard bench for pc_sequencer
module tb_pc_sequencer;
  logic clk = 0, rst_n = 0, stall = 0, halt = 0, br_en = 0, br_reg = 0, call = 0, ret = 0;
  logic [2:0] cond = 0, flags = 0;
  logic [8:0] imm = 0;
  logic [15:0] reg_target = 0;
  logic [15:0] pc, pc_plus2;
  logic taken, halted, ras_empty, ras_full, ras_err;
  int tests = 0, fails = 0;
  logic [15:0] pc_q[$];
  logic err_q[$];
  pc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .halt(halt), .br_en(br_en), .br_reg(br_reg),
    .cond(cond), .flags(flags), .imm(imm), .reg_target(reg_target), .call(call), .ret(ret),
    .pc(pc), .pc_plus2(pc_plus2), .taken(taken), .halted(halted),
    .ras_empty(ras_empty), .ras_full(ras_full), .ras_err(ras_err)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  function automatic logic exp_cond(input logic [2:0] c, input logic [2:0] f);
    logic n, z, v;
    n = f[0];
    z = f[1];
    v = f[2];
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || !n;
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input string tag, input logic tk, input logic [15:0] p, input logic err);
    logic [15:0] ep;
    logic ee;
    #1;
    check({tag, "_taken"}, 32'(taken), 32'(tk));
    pc_q.push_back(p);
    err_q.push_back(err);
    @(posedge clk);
    #1;
    ep = pc_q.pop_front();
    ee = err_q.pop_front();
    check({tag, "_pc"}, 32'(pc), 32'(ep));
    check({tag, "_err"}, 32'(ras_err), 32'(ee));
    @(negedge clk);
  endtask
  task automatic jump(input logic [15:0] a);
    br_en = 1; br_reg = 1; cond = 3'b111; reg_target = a;
    cyc("jump", 1'b1, a, 1'b0);
    br_en = 0; br_reg = 0;
  endtask
  initial begin
    #1;
    check("rst_pc", 32'(pc), 32'h0);
    check("rst_halted", 32'(halted), 0);
    check("rst_empty", 32'(ras_empty), 1);
    check("rst_full", 32'(ras_full), 0);
    check("rst_err", 32'(ras_err), 0);
    check("rst_taken", 32'(taken), 0);
    @(negedge clk);
    rst_n = 1;
    cyc("seq0", 1'b0, 16'h0002, 1'b0);
    // condition sweep around pc=0x0010 with a -1 halfword offset
    jump(16'h0010);
    br_en = 1; br_reg = 0; imm = 9'h1FF;
    for (int c = 0; c < 8; c++)
      for (int f = 0; f < 8; f++) begin
        cond = 3'(c);
        flags = 3'(f);
        #1;
        check($sformatf("cond%0d_f%0d", c, f), 32'(taken), 32'(exp_cond(3'(c), 3'(f))));
      end
    cond = 3'b111; flags = 3'b000;
    cyc("br_self", 1'b1, 16'h0010, 1'b0);
    cond = 3'b001;
    cyc("br_not", 1'b0, 16'h0012, 1'b0);
    br_en = 0;
    jump(16'hFFFE);
    cyc("wrap", 1'b0, 16'h0000, 1'b0);
    br_en = 1; cond = 3'b111; imm = 9'h100;
    cyc("neg_imm", 1'b1, 16'hFE02, 1'b0);
    br_en = 0;
    // five calls into a four-deep stack, then five returns
    jump(16'h0100);
    call = 1; br_reg = 1;
    for (int i = 2; i <= 6; i++) begin
      reg_target = 16'(i * 16'h0100);
      cyc("call", 1'b1, reg_target, 1'b0);
      if (i == 5) check("full_after4", 32'(ras_full), 1);
    end
    check("full_after5", 32'(ras_full), 1);
    check("nonempty", 32'(ras_empty), 0);
    call = 0; br_reg = 0; ret = 1;
    cyc("ret1", 1'b1, 16'h0502, 1'b0);
    cyc("ret2", 1'b1, 16'h0402, 1'b0);
    cyc("ret3", 1'b1, 16'h0302, 1'b0);
    cyc("ret4", 1'b1, 16'h0202, 1'b0);
    check("empty_after4", 32'(ras_empty), 1);
    cyc("ret_empty", 1'b0, 16'h0204, 1'b1);
    ret = 0;
    cyc("err_clr", 1'b0, 16'h0206, 1'b0);
    call = 1; br_reg = 1; reg_target = 16'h0700;
    cyc("call1", 1'b1, 16'h0700, 1'b0);
    ret = 1;
    cyc("callret", 1'b0, 16'h0702, 1'b1);
    call = 0; ret = 0;
    cyc("callret_clr", 1'b0, 16'h0704, 1'b0);
    check("callret_cnt", 32'(ras_empty), 0);
    ret = 1;
    cyc("ret_link", 1'b1, 16'h0208, 1'b0);
    ret = 0;
    check("empty_again", 32'(ras_empty), 1);
    // stall across a taken branch
    br_en = 1; br_reg = 1; cond = 3'b111; reg_target = 16'h0A00; stall = 1;
    for (int i = 0; i < 3; i++) cyc("stall", 1'b1, 16'h0208, 1'b0);
    stall = 0;
    cyc("unstall", 1'b1, 16'h0A00, 1'b0);
    br_en = 0; call = 1; reg_target = 16'h0B00;
    cyc("call_b", 1'b1, 16'h0B00, 1'b0);
    call = 0; br_en = 1; halt = 1; reg_target = 16'h0C00;
    cyc("halt", 1'b0, 16'h0B00, 1'b0);
    check("halted", 32'(halted), 1);
    halt = 0; call = 1;
    cyc("halted_br", 1'b0, 16'h0B00, 1'b0);
    call = 0; ret = 1;
    cyc("halted_ret", 1'b0, 16'h0B00, 1'b0);
    check("halted_sticky", 32'(halted), 1);
    check("halted_ras", 32'(ras_empty), 0);
    ret = 0;
    // asynchronous reset away from any clock edge
    #2 rst_n = 0;
    #1;
    check("arst_pc", 32'(pc), 32'h0);
    check("arst_halted", 32'(halted), 0);
    check("arst_empty", 32'(ras_empty), 1);
    check("arst_taken", 32'(taken), 0);
    br_en = 0; br_reg = 0;
    @(negedge clk);
    rst_n = 1;
    cyc("post_rst", 1'b0, 16'h0002, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
